// File: rtl/ahb_cfg_slave.sv
// Purpose : AHB-Lite slave exposing a word-addressed CTRL/STATUS/CFG register bank.
// Latency : OKAY data phase = WAIT_STATES hready-low cycles + 1; ERROR = 2 cycles.
// Backpr. : stalls the bus with hready=0 during wait/ERR1; pipelined accept in DONE/ERR2.
//
// Ports:
//   ahb_hclk, ahb_hresetn       clock, synchronous active-low reset
//   ahb_hsel/htrans/hburst/     address-phase controls (hburst ignored; every beat
//   hsize/hwrite/haddr          is decoded on its own)
//   ahb_hwdata                  write data, data phase
//   ahb_hready_in               bus-level ready (previous transfer completing)
//   ahb_hrdata/hready/hresp     slave data-phase response
//   status_in                   core status, visible at register index 1
//   cfg_flat                    all registers flattened, slot i = register i
//   start_pulse                 one-cycle strobe after a CTRL write with bit0 set
module ahb_cfg_slave #(
  parameter int BUSWIDTH    = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic                         ahb_hclk,
  input  logic                         ahb_hresetn,
  input  logic                         ahb_hsel,
  input  logic [1:0]                   ahb_htrans,
  input  logic [2:0]                   ahb_hburst,
  input  logic [2:0]                   ahb_hsize,
  input  logic                         ahb_hwrite,
  input  logic [BUSWIDTH-1:0]          ahb_haddr,
  input  logic [BUSWIDTH-1:0]          ahb_hwdata,
  input  logic                         ahb_hready_in,
  output logic [BUSWIDTH-1:0]          ahb_hrdata,
  output logic                         ahb_hready,
  output logic                         ahb_hresp,
  input  logic [BUSWIDTH-1:0]          status_in,
  output logic [NUM_REGS*BUSWIDTH-1:0] cfg_flat,
  output logic                         start_pulse
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                start_q, start_d;
  logic [BUSWIDTH-1:0] regs_q [NUM_REGS];
  logic [BUSWIDTH-1:0] regs_d [NUM_REGS];

  logic             slave_rdy;
  logic             accept;
  logic             addr_err;
  logic [IDX_W-1:0] addr_idx;

  // Burst kind, the SEQ/NONSEQ distinction and the high address bits carry no
  // information for this slave: the external decoder already produced hsel.
  logic unused_bits;
  assign unused_bits = ^{ahb_hburst, ahb_htrans[0], ahb_haddr[BUSWIDTH-1:ADDR_W]};

  // The slave can take a new address phase only in cycles where it drives hready=1.
  assign slave_rdy = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept    = ahb_hsel && ahb_hready_in && ahb_htrans[1] && slave_rdy;
  assign addr_idx  = ahb_haddr[ADDR_W-1:2];

  // STATUS (index 1) is read-only, so a write there is rejected like a bad address.
  assign addr_err = (32'(addr_idx) >= NUM_REGS)
                 || (ahb_haddr[1:0] != 2'b00)
                 || (ahb_hsize != 3'b010)
                 || (ahb_hwrite && (32'(addr_idx) == 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    regs_d  = regs_q;

    // Commit happens on the edge that closes DONE, so a read pipelined behind
    // this write in the same edge already sees the new value.
    if (state_q == ST_DONE && wr_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i != 1 && 32'(idx_q) == i) begin
          regs_d[i] = ahb_hwdata;
          if (i == 0) begin
            // CTRL bit0 is a command, not state: it fires the pulse and reads back 0.
            regs_d[0][0] = 1'b0;
            start_d      = ahb_hwdata[0];
          end
        end
      end
    end

    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        if (accept) begin
          wr_d  = ahb_hwrite;
          idx_d = addr_idx;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ahb_hclk) begin
    if (!ahb_hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    ahb_hrdata = '0;
    if (state_q == ST_DONE && !wr_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(idx_q) == i) begin
          ahb_hrdata = (i == 1) ? status_in : regs_q[i];
        end
      end
    end
  end

  always_comb begin
    cfg_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_flat[i*BUSWIDTH +: BUSWIDTH] = (i == 1) ? status_in : regs_q[i];
    end
  end

  assign ahb_hready  = slave_rdy;
  assign ahb_hresp   = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign start_pulse = start_q;

endmodule
